// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: width defaults, owner encoding, burst counter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int BURST_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } own_state_e;

    typedef logic [BURST_W-1:0] burst_cnt_t;

    function automatic burst_cnt_t burst_inc(input burst_cnt_t cnt, input burst_cnt_t max_cnt);
        return (cnt >= max_cnt) ? max_cnt : burst_cnt_t'(cnt + 1'b1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a burst limit; combinational grant, zero latency.
// Grants are forced low while rst_n is asserted so nothing leaks out during reset.
module rr_arb2
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam burst_cnt_t MAX_CNT = burst_cnt_t'(MAX_BURST);

    own_state_e state;
    own_state_e state_nxt;
    logic       last_b;
    logic       last_b_nxt;
    burst_cnt_t burst_cnt;
    burst_cnt_t burst_cnt_nxt;
    logic [1:0] gnt_pick;

    always_comb begin
        gnt_pick = 2'b00;
        case (req)
            2'b01: gnt_pick = 2'b01;
            2'b10: gnt_pick = 2'b10;
            2'b11: begin
                // Contention: the current owner keeps the port until its burst is used up.
                case (state)
                    IDLE:    gnt_pick = last_b ? 2'b01 : 2'b10;
                    OWN_A:   gnt_pick = (burst_cnt < MAX_CNT) ? 2'b01 : 2'b10;
                    OWN_B:   gnt_pick = (burst_cnt < MAX_CNT) ? 2'b10 : 2'b01;
                    default: gnt_pick = 2'b01;
                endcase
            end
            default: gnt_pick = 2'b00;
        endcase
        gnt = gnt_pick & {2{rst_n}};
    end

    always_comb begin
        state_nxt     = IDLE;
        last_b_nxt    = last_b;
        burst_cnt_nxt = burst_cnt;
        if (gnt[0]) begin
            state_nxt     = OWN_A;
            last_b_nxt    = 1'b0;
            burst_cnt_nxt = (state == OWN_A) ? burst_inc(burst_cnt, MAX_CNT) : burst_cnt_t'(1);
        end else if (gnt[1]) begin
            state_nxt     = OWN_B;
            last_b_nxt    = 1'b1;
            burst_cnt_nxt = (state == OWN_B) ? burst_inc(burst_cnt, MAX_CNT) : burst_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last_b    <= last_b_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port between requesters A and B.
// Grant is same-cycle; read data returns one cycle after a read grant to whoever issued it.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    logic [1:0] gnt;
    logic       rd_pend;
    logic       rd_owner;

    rr_arb2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({b_req, a_req}),
        .gnt   (gnt)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

    always_comb begin
        ram_we      = 1'b0;
        ram_wr_addr = '0;
        ram_rd_addr = '0;
        ram_data    = '0;
        if (a_gnt) begin
            ram_we      = a_we;
            ram_wr_addr = a_addr;
            ram_rd_addr = a_addr;
            ram_data    = a_wdata;
        end else if (b_gnt) begin
            ram_we      = b_we;
            ram_wr_addr = b_addr;
            ram_rd_addr = b_addr;
            ram_data    = b_wdata;
        end
    end

    // rd_owner: 0 = A, 1 = B; only meaningful while rd_pend is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= (a_gnt && !a_we) || (b_gnt && !b_we);
            rd_owner <= b_gnt;
        end
    end

    assign a_rvalid = rd_pend && !rd_owner;
    assign b_rvalid = rd_pend &&  rd_owner;
    assign a_rdata  = a_rvalid ? ram_q : '0;
    assign b_rdata  = b_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-output RAM attached.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [5:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_we;
    logic [5:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_data;
    logic [7:0] ram_q = 8'h00;
    logic [7:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W    (6),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_gnt       (a_gnt),
        .a_rvalid    (a_rvalid),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_gnt       (b_gnt),
        .b_rvalid    (b_rvalid),
        .b_rdata     (b_rdata),
        .ram_we      (ram_we),
        .ram_wr_addr (ram_wr_addr),
        .ram_rd_addr (ram_rd_addr),
        .ram_data    (ram_data),
        .ram_q       (ram_q)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_data;
        else        ram_q <= mem[ram_rd_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        a_req = 1; a_we = 1; a_addr = 6'd9; a_wdata = 8'hFF;
        b_req = 1; b_addr = 6'd7;
        #1;
        checks++;
        if ({a_gnt, b_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", {a_gnt, b_gnt}); end
        checks++;
        if ({ram_we, ram_wr_addr, ram_rd_addr, ram_data} !== 21'd0) begin
            errors++; $display("FAIL reset_ram got we=%b wa=%h ra=%h d=%h exp=0", ram_we, ram_wr_addr, ram_rd_addr, ram_data);
        end
        step();
        checks++;
        if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== 18'd0) begin
            errors++; $display("FAIL reset_rd got av=%b bv=%b ad=%h bd=%h exp=0", a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        do_reset();
    endtask

    task automatic test_write_read();
        a_req = 1; a_we = 1; a_addr = 6'd3; a_wdata = 8'h5A;
        #1;
        checks++;
        if ({a_gnt, b_gnt, ram_we, ram_wr_addr, ram_data} !== {3'b101, 6'd3, 8'h5A}) begin
            errors++; $display("FAIL wr_cmd got g=%b%b we=%b wa=%h d=%h exp g=10 we=1 wa=03 d=5a", a_gnt, b_gnt, ram_we, ram_wr_addr, ram_data);
        end
        step();
        a_we = 0;
        #1;
        checks++;
        if ({a_gnt, ram_we, ram_rd_addr, a_rvalid} !== {2'b10, 6'd3, 1'b0}) begin
            errors++; $display("FAIL rd_cmd got g=%b we=%b ra=%h av=%b exp g=1 we=0 ra=03 av=0", a_gnt, ram_we, ram_rd_addr, a_rvalid);
        end
        step();
        a_req = 0;
        #1;
        checks++;
        if ({a_rvalid, a_rdata, b_rvalid} !== {1'b1, 8'h5A, 1'b0}) begin
            errors++; $display("FAIL rd_data got av=%b ad=%h bv=%b exp av=1 ad=5a bv=0", a_rvalid, a_rdata, b_rvalid);
        end
        step();
        checks++;
        if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_single got av=%b exp 0", a_rvalid); end
    endtask

    task automatic test_tie_from_reset();
        do_reset();
        a_req = 1; a_addr = 6'd1;
        b_req = 1; b_addr = 6'd2;
        #1;
        checks++;
        if ({a_gnt, b_gnt, ram_rd_addr} !== {2'b10, 6'd1}) begin
            errors++; $display("FAIL tie_first got g=%b%b ra=%h exp g=10 ra=01", a_gnt, b_gnt, ram_rd_addr);
        end
        step();
        a_req = 0;
        #1;
        checks++;
        if ({a_gnt, b_gnt, a_rvalid, a_rdata} !== {3'b011, 8'h11}) begin
            errors++; $display("FAIL tie_second got g=%b%b av=%b ad=%h exp g=01 av=1 ad=11", a_gnt, b_gnt, a_rvalid, a_rdata);
        end
        step();
        b_req = 0;
        #1;
        checks++;
        if ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, 8'h12}) begin
            errors++; $display("FAIL alt_rvalid got av=%b bv=%b bd=%h exp av=0 bv=1 bd=12", a_rvalid, b_rvalid, b_rdata);
        end
        step();
    endtask

    task automatic test_burst();
        logic [11:0] pat;
        logic        prev_a;
        pat = 12'b1111_0000_1111;
        do_reset();
        a_req = 1; a_addr = 6'd4;
        b_req = 1; b_addr = 6'd5;
        prev_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if ({a_gnt, b_gnt} !== {pat[11-i], ~pat[11-i]}) begin
                errors++; $display("FAIL burst_gnt cyc=%0d got=%b%b exp=%b%b", i, a_gnt, b_gnt, pat[11-i], ~pat[11-i]);
            end
            if (i > 0) begin
                checks++;
                if ({a_rvalid, b_rvalid} !== {prev_a, ~prev_a}) begin
                    errors++; $display("FAIL burst_rvalid cyc=%0d got=%b%b exp=%b%b", i, a_rvalid, b_rvalid, prev_a, ~prev_a);
                end
            end
            prev_a = pat[11-i];
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_write_then_read();
        do_reset();
        b_req = 1; b_we = 1; b_addr = 6'd63; b_wdata = 8'hC3;
        #1;
        checks++;
        if ({b_gnt, ram_we, ram_wr_addr, ram_data} !== {2'b11, 6'd63, 8'hC3}) begin
            errors++; $display("FAIL b_wr got g=%b we=%b wa=%h d=%h exp g=1 we=1 wa=3f d=c3", b_gnt, ram_we, ram_wr_addr, ram_data);
        end
        step();
        b_req = 0; b_we = 0;
        a_req = 1; a_addr = 6'd63;
        #1;
        checks++;
        if ({a_gnt, b_rvalid, a_rvalid} !== 3'b100) begin
            errors++; $display("FAIL a_rd_after_wr got g=%b bv=%b av=%b exp 100", a_gnt, b_rvalid, a_rvalid);
        end
        step();
        a_req = 0;
        #1;
        checks++;
        if ({a_rvalid, a_rdata, b_rvalid} !== {1'b1, 8'hC3, 1'b0}) begin
            errors++; $display("FAIL raw_data got av=%b ad=%h bv=%b exp av=1 ad=c3 bv=0", a_rvalid, a_rdata, b_rvalid);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        a_req = 1; a_addr = 6'd8;
        #1;
        checks++;
        if (a_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got=%b exp=1", a_gnt); end
        #1;
        rst_n = 0;
        #1;
        checks++;
        if ({a_gnt, b_gnt, ram_we, ram_rd_addr, ram_wr_addr, ram_data, a_rvalid, a_rdata} !== 30'd0) begin
            errors++; $display("FAIL mid_rst_out got g=%b we=%b ra=%h av=%b ad=%h exp all 0", a_gnt, ram_we, ram_rd_addr, a_rvalid, a_rdata);
        end
        step();
        a_req = 0;
        checks++;
        if ({a_rvalid, a_rdata} !== 9'd0) begin errors++; $display("FAIL mid_rst_edge got av=%b ad=%h exp 0", a_rvalid, a_rdata); end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_after cyc=%0d got av=%b exp 0", i, a_rvalid); end
        end
    endtask

    task automatic test_only_b();
        do_reset();
        b_req = 1; b_addr = 6'd10;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({a_gnt, b_gnt} !== 2'b01) begin
                errors++; $display("FAIL only_b cyc=%0d got=%b%b exp=01", i, a_gnt, b_gnt);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h10 + 8'(i);
        idle_inputs();
        rst_n = 0;
        step();
        test_reset();
        test_write_read();
        test_tie_from_reset();
        test_burst();
        test_write_then_read();
        test_reset_mid_read();
        test_only_b();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
